// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch flush,
// load-use interlock, plus a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter logic [5:0] OP_NOP  = 6'd55,
  parameter logic [5:0] OP_LD   = 6'd16,
  parameter logic [5:0] OP_ST   = 6'd24,
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [5:0]  id_op,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [5:0]  ex_op,
  input  logic [4:0]  ex_wreg,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        id_flush,
  output logic        ex_bubble,
  output logic        wb_bubble,
  output logic        pc_sel,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic is_ld, is_mem, rs_hit, rt_hit, load_use, timed_out;

  // A bubble never requests memory, even if the opcode parameters collide.
  assign is_ld     = (ex_op == OP_LD) && (ex_op != OP_NOP);
  assign is_mem    = ((ex_op == OP_LD) || (ex_op == OP_ST)) && (ex_op != OP_NOP);
  assign rs_hit    = (ex_wreg == id_rs);
  assign rt_hit    = (ex_wreg == id_rt);
  assign load_use  = is_ld && mem_ack && (ex_wreg != 5'd0) && (rs_hit || rt_hit);
  assign timed_out = ({1'b0, wait_cnt_q} + 9'd1) >= {1'b0, TIMEOUT};

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    mem_req    = 1'b0;
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    ex_stall   = 1'b0;
    id_flush   = 1'b0;
    ex_bubble  = 1'b0;
    wb_bubble  = 1'b0;
    pc_sel     = 1'b0;

    unique case (state_q)
      StRun: begin
        mem_req = is_mem;
        if (is_mem && !mem_ack) begin
          if_stall   = 1'b1;
          id_stall   = 1'b1;
          ex_stall   = 1'b1;
          wb_bubble  = 1'b1;
          state_d    = StWait;
          wait_cnt_d = 8'd0;
        end else if (br_taken) begin
          pc_sel    = 1'b1;
          id_flush  = 1'b1;
          ex_bubble = 1'b1;
        end else if (load_use) begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
        end
      end
      StWait: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end else begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_stall  = 1'b1;
          wb_bubble = 1'b1;
          if (timed_out) begin
            state_d   = StErr;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      StErr: begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_stall  = 1'b1;
        ex_bubble = 1'b1;
        wb_bubble = 1'b1;
      end
      default: state_d = StRun;
    endcase

    // Reset overrides everything: pipeline registers fill with bubbles.
    if (!rstd) begin
      mem_req   = 1'b0;
      if_stall  = 1'b0;
      id_stall  = 1'b0;
      ex_stall  = 1'b0;
      id_flush  = 1'b0;
      pc_sel    = 1'b0;
      ex_bubble = 1'b1;
      wb_bubble = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (if_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule
